pfd_tdc: RTL

//  Parametrised digital phase-frequency detector with time-to-digital measurement. Samples

---
 rtl/pfd_tdc.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/pfd_tdc.sv
// Phase-frequency detector with time-to-digital edge-offset measurement for the PLL loop filter.
// Optional lock detector is built only when PFD_LOCK_DETECT_EN is defined; otherwise lock is tied 0.
module pfd_tdc #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ref_in,
  input  logic             fb_in,
  output logic             up,
  output logic             dn,
  output logic [CNT_W-1:0] phase_err,
  output logic             err_valid,
  output logic             err_sat,
  output logic             slip,
  output logic             lock
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REF_LEAD = 2'd1,
    ST_FB_LEAD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [SYNC_STAGES-1:0] ref_sync_q, ref_sync_d, fb_sync_q, fb_sync_d;
  logic                   ref_dly_q, ref_dly_d, fb_dly_q, fb_dly_d;
  logic                   rr_s, fr_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc_s;
  logic [CNT_W-1:0]       phase_err_q, phase_err_d;
  logic                   err_valid_q, err_valid_d;
  logic                   err_sat_q, err_sat_d;
  logic                   slip_q, slip_d;
  logic                   up_q, up_d, dn_q, dn_d;

  // Synchroniser shift and rise detection; keeps running while disabled so no stale edge survives.
  always_comb begin
    ref_sync_d = {ref_sync_q[SYNC_STAGES-2:0], ref_in};
    fb_sync_d  = {fb_sync_q[SYNC_STAGES-2:0], fb_in};
    ref_dly_d  = ref_sync_q[SYNC_STAGES-1];
    fb_dly_d   = fb_sync_q[SYNC_STAGES-1];
    rr_s       = ref_sync_q[SYNC_STAGES-1] & ~ref_dly_q;
    fr_s       = fb_sync_q[SYNC_STAGES-1] & ~fb_dly_q;
  end

  // Detector next state, measurement counter and result capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_err_d = phase_err_q;
    err_valid_d = 1'b0;
    err_sat_d   = 1'b0;
    slip_d      = 1'b0;
    cnt_inc_s   = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_ONE);
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rr_s && fr_s) begin
            err_valid_d = 1'b1;
            phase_err_d = CNT_ZERO;
            cnt_d       = CNT_ZERO;
          end else if (rr_s) begin
            state_d = ST_REF_LEAD;
            cnt_d   = CNT_ONE;
          end else if (fr_s) begin
            state_d = ST_FB_LEAD;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = CNT_ZERO;
          end
        end
        ST_REF_LEAD: begin
          if (fr_s) begin
            err_valid_d = 1'b1;
            phase_err_d = cnt_q;
            err_sat_d   = (cnt_q == CNT_MAX);
            // A fresh leading edge in the closing cycle starts the next measurement at once.
            state_d     = rr_s ? ST_REF_LEAD : ST_IDLE;
            cnt_d       = rr_s ? CNT_ONE : CNT_ZERO;
          end else if (rr_s) begin
            slip_d = 1'b1;
            cnt_d  = cnt_inc_s;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        ST_FB_LEAD: begin
          if (rr_s) begin
            err_valid_d = 1'b1;
            phase_err_d = ~cnt_q + CNT_ONE;
            err_sat_d   = (cnt_q == CNT_MAX);
            state_d     = fr_s ? ST_FB_LEAD : ST_IDLE;
            cnt_d       = fr_s ? CNT_ONE : CNT_ZERO;
          end else if (fr_s) begin
            slip_d = 1'b1;
            cnt_d  = cnt_inc_s;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
    up_d = (state_d == ST_REF_LEAD);
    dn_d = (state_d == ST_FB_LEAD);
  end

  // State, synchroniser and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_sync_q  <= {SYNC_STAGES{1'b0}};
      fb_sync_q   <= {SYNC_STAGES{1'b0}};
      ref_dly_q   <= 1'b0;
      fb_dly_q    <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      phase_err_q <= CNT_ZERO;
      err_valid_q <= 1'b0;
      err_sat_q   <= 1'b0;
      slip_q      <= 1'b0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
    end else begin
      ref_sync_q  <= ref_sync_d;
      fb_sync_q   <= fb_sync_d;
      ref_dly_q   <= ref_dly_d;
      fb_dly_q    <= fb_dly_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_err_q <= phase_err_d;
      err_valid_q <= err_valid_d;
      err_sat_q   <= err_sat_d;
      slip_q      <= slip_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
    end
  end

  assign up        = up_q;
  assign dn        = dn_q;
  assign phase_err = phase_err_q;
  assign err_valid = err_valid_q;
  assign err_sat   = err_sat_q;
  assign slip      = slip_q;

`ifdef PFD_LOCK_DETECT_EN
  localparam int                 LK_W   = $clog2(LOCK_CYCLES + 1);
  localparam logic [LK_W-1:0]    LK_MAX = LK_W'(LOCK_CYCLES);
  localparam logic [LK_W-1:0]    LK_ONE = {{(LK_W-1){1'b0}}, 1'b1};
  localparam logic signed [CNT_W-1:0] TOL_P = CNT_W'(LOCK_TOL);
  localparam logic signed [CNT_W-1:0] TOL_N = -TOL_P;

  logic [LK_W-1:0] run_q, run_d;
  logic            lock_q, lock_d;
  logic            in_tol_s;

  // Count consecutive in-tolerance strobes; any bad result or disable restarts the run.
  always_comb begin
    in_tol_s = ($signed(phase_err_q) <= TOL_P) && ($signed(phase_err_q) >= TOL_N);
    if (!en || slip_q || (err_valid_q && (err_sat_q || !in_tol_s))) begin
      run_d = {LK_W{1'b0}};
    end else if (err_valid_q && (run_q != LK_MAX)) begin
      run_d = run_q + LK_ONE;
    end else begin
      run_d = run_q;
    end
    lock_d = (run_d == LK_MAX);
  end

  // Lock run counter and indicator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= {LK_W{1'b0}};
      lock_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      lock_q <= lock_d;
    end
  end

  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

endmodule
